// File: rtl/cmp_pkg.sv
// Shared comparator-side definitions: relation state encoding and flag decode.
package cmp_pkg;

  localparam logic [1:0] ST_UNKNOWN = 2'b00;
  localparam logic [1:0] ST_BELOW   = 2'b01;
  localparam logic [1:0] ST_EQUAL   = 2'b10;
  localparam logic [1:0] ST_ABOVE   = 2'b11;

  typedef struct packed {
    logic       legal;
    logic [1:0] st;
  } cmp_dec_t;

  // Only exactly one-hot {le,eq,gr} is a legal comparator result.
  function automatic cmp_dec_t cmp_decode(input logic le, input logic eq, input logic gr);
    cmp_dec_t d;
    d.legal = 1'b1;
    d.st    = ST_UNKNOWN;
    case ({le, eq, gr})
      3'b100:  d.st = ST_BELOW;
      3'b010:  d.st = ST_EQUAL;
      3'b001:  d.st = ST_ABOVE;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/cmp_persist_filter.sv
// Persistence filter: tracks a candidate class and how many consecutive
// legal samples agreed with it; strobes commit when the run reaches PERSIST.
module cmp_persist_filter
  import cmp_pkg::*;
#(
  parameter int PERSIST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       smp_vld,
  input  logic [1:0] smp_st,
  input  logic [1:0] cur_st,
  output logic       commit,
  output logic [1:0] commit_st
);

  localparam logic [3:0] RUN_MAX = 4'(PERSIST);

  logic [1:0] cand_p0, cand_nxt;
  logic [3:0] run_p0, run_nxt;

  function automatic logic [3:0] run_sat_inc(input logic [3:0] r);
    return (r >= RUN_MAX) ? RUN_MAX : r + 4'd1;
  endfunction

  always_comb begin
    cand_nxt = cand_p0;
    run_nxt  = run_p0;
    if (smp_vld) begin
      if (smp_st == cand_p0) begin
        run_nxt = run_sat_inc(run_p0);
      end else begin
        cand_nxt = smp_st;
        run_nxt  = 4'd1;
      end
    end
  end

  // Commit is evaluated on the updated run so it lands on the sampling edge.
  assign commit    = smp_vld && (run_nxt == RUN_MAX) && (cand_nxt != cur_st);
  assign commit_st = cand_nxt;

  // ---- stage p0: candidate / run registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_p0 <= ST_UNKNOWN;
      run_p0  <= 4'd0;
    end else begin
      cand_p0 <= cand_nxt;
      run_p0  <= run_nxt;
    end
  end

endmodule

// File: rtl/cmp_trend_monitor.sv
// Debounced relation tracker downstream of the 8-bit comparator: commits
// BELOW/EQUAL/ABOVE, pulses on crossings, counts them and flags bad flag sets.
module cmp_trend_monitor
  import cmp_pkg::*;
#(
  parameter int PERSIST = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             le,
  input  logic             eq,
  input  logic             gr,
  input  logic             clr,
  output logic [1:0]       state_out,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] cross_cnt,
  output logic             err
);

  cmp_dec_t   dec_p0;
  logic       vld_p0;
  logic       bad_p0;
  logic       commit;
  logic [1:0] commit_st;
  logic       rise_nxt;
  logic       fall_nxt;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign dec_p0 = cmp_decode(le, eq, gr);
  assign vld_p0 = in_valid && dec_p0.legal;
  assign bad_p0 = in_valid && !dec_p0.legal;

  cmp_persist_filter #(
    .PERSIST (PERSIST)
  ) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .smp_vld   (vld_p0),
    .smp_st    (dec_p0.st),
    .cur_st    (state_out),
    .commit    (commit),
    .commit_st (commit_st)
  );

  // Leaving UNKNOWN or entering EQUAL is never a crossing.
  assign rise_nxt = commit && (commit_st == ST_ABOVE) &&
                    ((state_out == ST_BELOW) || (state_out == ST_EQUAL));
  assign fall_nxt = commit && (commit_st == ST_BELOW) &&
                    ((state_out == ST_ABOVE) || (state_out == ST_EQUAL));

  // ---- stage p1: committed state, pulses, counter, error flag ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_out  <= ST_UNKNOWN;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      cross_cnt  <= '0;
      err        <= 1'b0;
    end else begin
      if (commit) state_out <= commit_st;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      if (clr)                       cross_cnt <= '0;
      else if (rise_nxt || fall_nxt) cross_cnt <= cnt_sat_inc(cross_cnt);
      if (clr)         err <= 1'b0;
      else if (bad_p0) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmp_trend_monitor.sv
// Table-driven scoreboard bench for cmp_trend_monitor: DUT A uses defaults,
// DUT B uses PERSIST=1, CNT_W=2 for the saturation sequence.
module tb_cmp_trend_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       le = 1'b0, eq = 1'b0, gr = 1'b0;
  logic       clr = 1'b0;
  logic [1:0] st_a, st_b;
  logic       rise_a, fall_a, err_a, rise_b, fall_b, err_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cmp_trend_monitor u_dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .le(le), .eq(eq), .gr(gr),
    .clr(clr), .state_out(st_a), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .cross_cnt(cnt_a), .err(err_a)
  );

  cmp_trend_monitor #(.PERSIST(1), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .le(le), .eq(eq), .gr(gr),
    .clr(clr), .state_out(st_b), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .cross_cnt(cnt_b), .err(err_b)
  );

  typedef struct {
    string      name;
    bit         rst;
    bit         dutb;
    bit         vld;
    logic [2:0] flags;
    bit         clr;
    logic [1:0] st;
    bit         rise;
    bit         fall;
    int         cnt;
    bit         err;
  } vec_t;

  localparam logic [2:0] LE = 3'b100, EQ = 3'b010, GR = 3'b001;

  vec_t tbl[$];
  vec_t sb[$];

  task automatic add(string n, bit r, bit b, bit v, logic [2:0] f, bit c,
                     logic [1:0] s, bit ri, bit fa, int cn, bit e);
    vec_t x;
    x.name = n; x.rst = r; x.dutb = b; x.vld = v; x.flags = f; x.clr = c;
    x.st = s; x.rise = ri; x.fall = fa; x.cnt = cn; x.err = e;
    tbl.push_back(x);
  endtask

  task automatic check(string n, bit b, logic [1:0] s, bit ri, bit fa, int cn, bit e);
    logic [20:0] act, exp;
    if (b) act = {st_b, rise_b, fall_b, 14'd0, cnt_b, err_b};
    else   act = {st_a, rise_a, fall_a, cnt_a, err_a};
    exp = {s, ri, fa, cn[15:0], e};
    checks++;
    if (act === exp) passed++;
    else
      $display("FAIL %s: got st=%b rise=%b fall=%b cnt=%0d err=%b, expected st=%b rise=%b fall=%b cnt=%0d err=%b",
               n, act[20:19], act[18], act[17], act[16:1], act[0], s, ri, fa, cn, e);
  endtask

  task automatic apply(vec_t v);
    vec_t e;
    @(negedge clk);
    if (v.rst) begin
      rst_n    = 1'b0;
      in_valid = 1'($urandom);
      {le, eq, gr} = 3'($urandom);
      clr      = 1'($urandom);
    end else begin
      rst_n    = 1'b1;
      in_valid = v.vld;
      {le, eq, gr} = v.flags;
      clr      = v.clr;
    end
    sb.push_back(v);
    if (v.rst) begin
      #1;
      check({v.name, "_async_a"}, 1'b0, 2'b00, 1'b0, 1'b0, 0, 1'b0);
      check({v.name, "_async_b"}, 1'b1, 2'b00, 1'b0, 1'b0, 0, 1'b0);
    end
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.name, e.dutb, e.st, e.rise, e.fall, e.cnt, e.err);
  endtask

  initial begin
    // reset
    add("reset0", 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add("reset1", 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    // first commit from UNKNOWN, then filtered fall
    for (int i = 1; i <= 3; i++) add("first_gr", 0, 0, 1, GR, 0, 2'b00, 0, 0, 0, 0);
    add("first_commit", 0, 0, 1, GR, 0, 2'b11, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("le_run_a", 0, 0, 1, LE, 0, 2'b11, 0, 0, 0, 0);
    add("eq_break", 0, 0, 1, EQ, 0, 2'b11, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("le_run_b", 0, 0, 1, LE, 0, 2'b11, 0, 0, 0, 0);
    add("fall_commit", 0, 0, 1, LE, 0, 2'b01, 0, 1, 1, 0);
    add("fall_one_cycle", 0, 0, 0, 0, 0, 2'b01, 0, 0, 1, 0);
    // gaps do not break a run
    for (int i = 0; i < 2; i++) add("gap_gr_a", 0, 0, 1, GR, 0, 2'b01, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) add("gap_idle", 0, 0, 0, GR, 0, 2'b01, 0, 0, 1, 0);
    add("gap_gr_b", 0, 0, 1, GR, 0, 2'b01, 0, 0, 1, 0);
    add("gap_rise", 0, 0, 1, GR, 0, 2'b11, 1, 0, 2, 0);
    add("rise_one_cycle", 0, 0, 0, 0, 0, 2'b11, 0, 0, 2, 0);
    // illegal flags inside a run
    for (int i = 0; i < 2; i++) add("ill_le_a", 0, 0, 1, LE, 0, 2'b11, 0, 0, 2, 0);
    add("ill_110", 0, 0, 1, 3'b110, 0, 2'b11, 0, 0, 2, 1);
    add("ill_le_b", 0, 0, 1, LE, 0, 2'b11, 0, 0, 2, 1);
    add("ill_commit", 0, 0, 1, LE, 0, 2'b01, 0, 1, 3, 1);
    add("clr_err", 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0);
    add("ill_novalid", 0, 0, 0, 3'b111, 0, 2'b01, 0, 0, 0, 0);
    add("clr_vs_ill", 0, 0, 1, 3'b111, 1, 2'b01, 0, 0, 0, 0);
    add("ill_000", 0, 0, 1, 3'b000, 0, 2'b01, 0, 0, 0, 1);
    add("clr_err2", 0, 0, 0, 0, 1, 2'b01, 0, 0, 0, 0);
    // clr coinciding with a pulse
    for (int i = 0; i < 3; i++) add("clrp_gr", 0, 0, 1, GR, 0, 2'b01, 0, 0, 0, 0);
    add("clr_vs_rise", 0, 0, 1, GR, 1, 2'b11, 1, 0, 0, 0);
    add("clrp_idle", 0, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0);
    // EQUAL commits never pulse; leaving EQUAL does
    for (int i = 0; i < 3; i++) add("eq_run", 0, 0, 1, EQ, 0, 2'b11, 0, 0, 0, 0);
    add("eq_commit", 0, 0, 1, EQ, 0, 2'b10, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("eq2le_run", 0, 0, 1, LE, 0, 2'b10, 0, 0, 0, 0);
    add("eq2le_fall", 0, 0, 1, LE, 0, 2'b01, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) add("le2eq", 0, 0, 1, EQ, 0, (i == 3) ? 2'b10 : 2'b01, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add("eq2gr_run", 0, 0, 1, GR, 0, 2'b10, 0, 0, 1, 0);
    add("eq2gr_rise", 0, 0, 1, GR, 0, 2'b11, 1, 0, 2, 0);
    // reset mid-run restarts the run
    add("mid_reset0", 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add("mid_gr_a", 0, 0, 1, GR, 0, 2'b00, 0, 0, 0, 0);
    add("mid_reset1", 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add("mid_gr_one", 0, 0, 1, GR, 0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) add("mid_gr_b", 0, 0, 1, GR, 0, 2'b00, 0, 0, 0, 0);
    add("mid_commit", 0, 0, 1, GR, 0, 2'b11, 0, 0, 0, 0);
    // saturation on DUT B (PERSIST=1, CNT_W=2)
    add("sat_reset", 1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    add("sat_le0", 0, 1, 1, LE, 0, 2'b01, 0, 0, 0, 0);
    add("sat_gr1", 0, 1, 1, GR, 0, 2'b11, 1, 0, 1, 0);
    add("sat_le2", 0, 1, 1, LE, 0, 2'b01, 0, 1, 2, 0);
    add("sat_gr3", 0, 1, 1, GR, 0, 2'b11, 1, 0, 3, 0);
    add("sat_le_hold", 0, 1, 1, LE, 0, 2'b01, 0, 1, 3, 0);
    add("sat_gr_hold", 0, 1, 1, GR, 0, 2'b11, 1, 0, 3, 0);
    add("sat_clr_fall", 0, 1, 1, LE, 1, 2'b01, 0, 1, 0, 0);
    add("sat_same_cls", 0, 1, 1, LE, 0, 2'b01, 0, 0, 0, 0);
    add("sat_rise_again", 0, 1, 1, GR, 0, 2'b11, 1, 0, 1, 0);

    foreach (tbl[i]) apply(tbl[i]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
